// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the CPU and a loader port.
// Round-robin grant, bounded loader bursts, per-owner tagged read return.
module ram_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          ld_lock,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_rden,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_rdata,
  output logic          last_owner,
  output logic [7:0]    cpu_stall_cnt
);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_e;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  owner_e        last_q;
  owner_e        tag_owner;
  logic          tag_valid;
  logic [3:0]    burst_cnt;
  logic [DW-1:0] cpu_hold;
  logic [DW-1:0] ld_hold;
  logic [7:0]    stall_q;
  logic          lock_ok;

  // Loader may keep the RAM only after it already owns it and budget remains.
  assign lock_ok = ld_lock
                && (last_q == OWN_LD)
                && (burst_cnt < BURST_LIM);

  always_comb begin
    cpu_gnt = 1'b0;
    ld_gnt  = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        cpu_req && !ld_req: cpu_gnt = 1'b1;
        ld_req && !cpu_req: ld_gnt  = 1'b1;
        cpu_req && ld_req: begin
          if (lock_ok || last_q == OWN_CPU) ld_gnt = 1'b1;
          else cpu_gnt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_rden  = 1'b0;
    ram_wren  = 1'b0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_wren  = cpu_we;
      ram_rden  = !cpu_we;
    end else if (ld_gnt) begin
      ram_addr  = ld_addr;
      ram_wdata = ld_wdata;
      ram_wren  = ld_we;
      ram_rden  = !ld_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q    <= OWN_LD;
      burst_cnt <= 4'd0;
      tag_valid <= 1'b0;
      tag_owner <= OWN_CPU;
      cpu_hold  <= '0;
      ld_hold   <= '0;
      stall_q   <= 8'd0;
    end else begin
      if (cpu_gnt) last_q <= OWN_CPU;
      else if (ld_gnt) last_q <= OWN_LD;

      if (cpu_gnt || !ld_lock) burst_cnt <= 4'd0;
      else if (ld_gnt && cpu_req && burst_cnt < BURST_LIM)
        burst_cnt <= burst_cnt + 4'd1;

      tag_valid <= ram_rden;
      tag_owner <= ld_gnt ? OWN_LD : OWN_CPU;

      if (cpu_rvalid) cpu_hold <= ram_rdata;
      if (ld_rvalid) ld_hold <= ram_rdata;

      if (cpu_req && !cpu_gnt && stall_q != 8'hFF)
        stall_q <= stall_q + 8'd1;
    end
  end

  // RAM data arrives the cycle after the grant; pass it through while tagged.
  assign cpu_rvalid    = tag_valid && (tag_owner == OWN_CPU);
  assign ld_rvalid     = tag_valid && (tag_owner == OWN_LD);
  assign cpu_rdata     = cpu_rvalid ? ram_rdata : cpu_hold;
  assign ld_rdata      = ld_rvalid ? ram_rdata : ld_hold;
  assign last_owner    = last_q;
  assign cpu_stall_cnt = stall_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter
// against a cycle-level reference model and a behavioural RAM.
module tb_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          ld_req = 1'b0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_lock = 1'b0;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [DW-1:0] ld_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_rden;
  logic          ram_wren;
  logic [DW-1:0] ram_rdata = '0;
  logic          last_owner;
  logic [7:0]    cpu_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_lock(ld_lock), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rden(ram_rden),
    .ram_wren(ram_wren), .ram_rdata(ram_rdata),
    .last_owner(last_owner), .cpu_stall_cnt(cpu_stall_cnt)
  );

  // Synchronous single-port RAM
  logic [7:0] mem [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    if (ram_rden) ram_rdata <= mem[ram_addr];
  end

  // Reference model state
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  logic       m_last;
  int         m_burst;
  logic [7:0] m_stall;
  logic       m_pv;
  logic       m_po;
  logic [7:0] m_pd;
  logic [7:0] m_cpu_hold;
  logic [7:0] m_ld_hold;
  logic       o_c;
  logic       o_l;
  logic [1:0] glog [$];

  task automatic chk1(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0b want %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last     = 1'b1;
    m_burst    = 0;
    m_stall    = 8'd0;
    m_pv       = 1'b0;
    m_po       = 1'b0;
    m_pd       = 8'd0;
    m_cpu_hold = 8'd0;
    m_ld_hold  = 8'd0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    cpu_req = 1'b1;
    ld_req  = 1'b1;
    ld_lock = 1'b0;
    cpu_we  = 1'b0;
    ld_we   = 1'b0;
    #1;
    chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk1("rst_ld_gnt", ld_gnt, 1'b0);
    chk1("rst_rden", ram_rden, 1'b0);
    chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("rst_ld_rvalid", ld_rvalid, 1'b0);
    chk8("rst_cpu_rdata", cpu_rdata, 8'h00);
    chk8("rst_ld_rdata", ld_rdata, 8'h00);
    chk1("rst_last_owner", last_owner, 1'b1);
    chk8("rst_stall", cpu_stall_cnt, 8'h00);
    @(negedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    rst     = 1'b0;
    model_reset();
  endtask

  // One clock cycle: check every output against the model, then advance it.
  task automatic step();
    logic       ec, el, erd, ewr, cv, lv;
    logic [7:0] ea, ewd, ecd, eld;
    #1;
    ec = 1'b0;
    el = 1'b0;
    if (cpu_req && ld_req) begin
      if (ld_lock && m_last && m_burst < MB) el = 1'b1;
      else begin
        el = !m_last;
        ec = m_last;
      end
    end else begin
      ec = cpu_req;
      el = ld_req;
    end
    ea  = ec ? cpu_addr : (el ? ld_addr : 8'h00);
    ewd = ec ? cpu_wdata : (el ? ld_wdata : 8'h00);
    ewr = (ec && cpu_we) || (el && ld_we);
    erd = (ec && !cpu_we) || (el && !ld_we);
    cv  = m_pv && !m_po;
    lv  = m_pv && m_po;
    ecd = cv ? m_pd : m_cpu_hold;
    eld = lv ? m_pd : m_ld_hold;
    chk1("cpu_gnt", cpu_gnt, ec);
    chk1("ld_gnt", ld_gnt, el);
    chk1("ram_rden", ram_rden, erd);
    chk1("ram_wren", ram_wren, ewr);
    chk8("ram_addr", ram_addr, ea);
    chk8("ram_wdata", ram_wdata, ewd);
    chk1("cpu_rvalid", cpu_rvalid, cv);
    chk1("ld_rvalid", ld_rvalid, lv);
    chk8("cpu_rdata", cpu_rdata, ecd);
    chk8("ld_rdata", ld_rdata, eld);
    chk1("last_owner", last_owner, m_last);
    chk8("stall_cnt", cpu_stall_cnt, m_stall);
    o_c = cpu_gnt;
    o_l = ld_gnt;
    glog.push_back({cpu_gnt, ld_gnt});
    @(posedge clk);
    if (cv) m_cpu_hold = m_pd;
    if (lv) m_ld_hold = m_pd;
    m_pv = erd;
    m_po = el;
    m_pd = ref_mem[ea];
    if (ewr) ref_mem[ea] = ewd;
    if (ec) m_last = 1'b0;
    else if (el) m_last = 1'b1;
    if (ec || !ld_lock) m_burst = 0;
    else if (el && cpu_req && m_burst < MB) m_burst++;
    if (cpu_req && !ec && m_stall != 8'hFF) m_stall++;
    @(negedge clk);
  endtask

  task automatic ld_write(logic [7:0] a, logic [7:0] d);
    ld_req   = 1'b1;
    ld_we    = 1'b1;
    ld_addr  = a;
    ld_wdata = d;
    step();
    ld_req = 1'b0;
  endtask

  task automatic check_pattern(string name, string pat);
    for (int i = 0; i < pat.len(); i++) begin
      chk1($sformatf("%s_c%0d", name, i), glog[i][1], pat[i] == "C");
      chk1($sformatf("%s_l%0d", name, i), glog[i][0], pat[i] == "L");
    end
  endtask

  initial begin
    model_reset();
    o_c = 1'b0;
    o_l = 1'b0;
    @(negedge clk);
    do_reset();

    // Preload program data through the loader
    ld_write(8'h10, 8'h5A);
    ld_write(8'h01, 8'h11);
    ld_write(8'h02, 8'h22);
    step();
    do_reset();

    // Single CPU read
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h10;
    step();
    chk1("t1_gnt", o_c, 1'b1);
    cpu_req = 1'b0;
    #1;
    chk1("t1_rvalid", cpu_rvalid, 1'b1);
    chk8("t1_rdata", cpu_rdata, 8'h5A);
    chk1("t1_ld_rvalid", ld_rvalid, 1'b0);
    step();

    // Round-robin with both requesting, no lock
    do_reset();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h01;
    ld_req   = 1'b1;
    ld_we    = 1'b0;
    ld_addr  = 8'h02;
    glog.delete();
    repeat (4) step();
    #1;
    chk8("alt_stall", cpu_stall_cnt, 8'd2);
    check_pattern("alt", "CLCL");
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    step();

    // Locked loader burst against a waiting CPU
    do_reset();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h40;
    ld_req   = 1'b1;
    ld_we    = 1'b1;
    ld_lock  = 1'b1;
    ld_addr  = 8'h20;
    ld_wdata = 8'hA0;
    glog.delete();
    repeat (10) begin
      step();
      if (o_l) begin
        ld_addr  = ld_addr + 8'd1;
        ld_wdata = ld_wdata + 8'd1;
      end
    end
    check_pattern("burst", "LLLLCLLLLC");
    chk8("burst_end_addr", ld_addr, 8'h28);
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    ld_lock = 1'b0;
    step();

    // Alternating reads return in order, one cycle late
    do_reset();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h01;
    step();
    cpu_req = 1'b0;
    ld_req  = 1'b1;
    ld_we   = 1'b0;
    ld_addr = 8'h02;
    #1;
    chk1("ar_cpu_rvalid", cpu_rvalid, 1'b1);
    chk8("ar_cpu_rdata", cpu_rdata, 8'h11);
    chk1("ar_ld_rvalid0", ld_rvalid, 1'b0);
    step();
    ld_req = 1'b0;
    #1;
    chk1("ar_ld_rvalid", ld_rvalid, 1'b1);
    chk8("ar_ld_rdata", ld_rdata, 8'h22);
    chk1("ar_cpu_rvalid1", cpu_rvalid, 1'b0);
    step();

    // Loader write followed by CPU read of the same word
    ld_write(8'h30, 8'hC3);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h30;
    #1;
    chk1("wr_no_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("wr_no_ld_rvalid", ld_rvalid, 1'b0);
    step();
    cpu_req = 1'b0;
    #1;
    chk1("wr_rd_rvalid", cpu_rvalid, 1'b1);
    chk8("wr_rd_rdata", cpu_rdata, 8'hC3);
    step();

    // Reset between grant and return drops the read
    cpu_req  = 1'b1;
    cpu_addr = 8'h10;
    step();
    do_reset();
    #1;
    chk1("mid_rst_rvalid", cpu_rvalid, 1'b0);
    chk8("mid_rst_rdata", cpu_rdata, 8'h00);
    repeat (2) step();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      if (!cpu_req || o_c) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 8'($urandom_range(0, 63));
        cpu_wdata = 8'($urandom);
      end
      if (!ld_req || o_l) begin
        ld_req   = ($urandom_range(0, 3) != 0);
        ld_we    = 1'($urandom_range(0, 1));
        ld_addr  = 8'($urandom_range(0, 63));
        ld_wdata = 8'($urandom);
      end
      ld_lock = ($urandom_range(0, 2) != 0);
      step();
    end
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    ld_lock = 1'b0;
    step();

    // Stall counter saturation under sustained loader pressure
    do_reset();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h05;
    ld_req   = 1'b1;
    ld_we    = 1'b1;
    ld_lock  = 1'b1;
    ld_addr  = 8'h80;
    ld_wdata = 8'h77;
    repeat (400) step();
    #1;
    chk8("stall_sat", cpu_stall_cnt, 8'hFF);
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
